// File: rtl/sobel_mag.sv
// Sobel gradient magnitude |Gx|+|Gy| over a 3x3 window, two-stage valid/ready pipeline.
// Optional binary edge map output when SOBEL_MAG_THRESHOLD_EN is defined (adds threshold_p).
module sobel_mag #(
  parameter int unsigned linewidth_px_p = 480,
  parameter int unsigned frame_height_p = 272,
  parameter int unsigned width_p        = 8
`ifdef SOBEL_MAG_THRESHOLD_EN
  , parameter int unsigned threshold_p  = 128
`endif
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [2:0][2:0][width_p-1:0]     kernel_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [width_p-1:0]               data_o
);

  localparam int unsigned col_w_lp = (linewidth_px_p > 1) ? $clog2(linewidth_px_p) : 1;
  localparam int unsigned row_w_lp = (frame_height_p > 1) ? $clog2(frame_height_p) : 1;
  localparam int unsigned pw_lp    = width_p + 2;
  localparam int unsigned gw_lp    = width_p + 3;
  localparam int unsigned sw_lp    = width_p + 4;

  logic                       v1_q, v1_d;
  logic                       v2_q, v2_d;
  logic                       adv2;
  logic                       in_xfer;
  logic                       ld2;
  logic [col_w_lp-1:0]        col_q, col_d;
  logic [row_w_lp-1:0]        row_q, row_d;
  logic signed [gw_lp-1:0]    gx_q, gx_d;
  logic signed [gw_lp-1:0]    gy_q, gy_d;
  logic                       border_q, border_d;
  logic [width_p-1:0]         data_q, data_d;

  logic [pw_lp-1:0]           gx_pos, gx_neg, gy_pos, gy_neg;
  logic                       col_last, row_last, border_new;
  logic [gw_lp-1:0]           gx_abs, gy_abs;
  logic [sw_lp-1:0]           sum;
  logic [width_p-1:0]         mag, pix;

  // Weighted 1-2-1 sum of three pixels; 4*(2^width_p-1) fits in width_p+2 bits.
  function automatic logic [pw_lp-1:0] wsum(input logic [width_p-1:0] a,
                                             input logic [width_p-1:0] b,
                                             input logic [width_p-1:0] c);
    return pw_lp'(a) + (pw_lp'(b) << 1) + pw_lp'(c);
  endfunction

  always_comb begin
    adv2    = ~v2_q | ready_i;
    ready_o = ~v1_q | adv2;
    in_xfer = valid_i & ready_o;
    ld2     = v1_q & adv2;
  end

  // Stage 1: gradients and border flag from the current frame position.
  always_comb begin
    gx_pos = wsum(kernel_i[0][2], kernel_i[1][2], kernel_i[2][2]);
    gx_neg = wsum(kernel_i[0][0], kernel_i[1][0], kernel_i[2][0]);
    gy_pos = wsum(kernel_i[2][0], kernel_i[2][1], kernel_i[2][2]);
    gy_neg = wsum(kernel_i[0][0], kernel_i[0][1], kernel_i[0][2]);

    col_last   = (col_q == col_w_lp'(linewidth_px_p - 1));
    row_last   = (row_q == row_w_lp'(frame_height_p - 1));
    border_new = (32'(row_q) < 32'd2) | (32'(col_q) < 32'd2);

    v1_d     = ready_o ? valid_i : v1_q;
    gx_d     = gx_q;
    gy_d     = gy_q;
    border_d = border_q;
    col_d    = col_q;
    row_d    = row_q;

    if (in_xfer) begin
      gx_d     = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
      gy_d     = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
      border_d = border_new;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Stage 2: absolute sum, saturation, border suppression.
  always_comb begin
    gx_abs = gx_q[gw_lp-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    gy_abs = gy_q[gw_lp-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    sum    = sw_lp'(gx_abs) + sw_lp'(gy_abs);
    mag    = (|sum[sw_lp-1:width_p]) ? '1 : sum[width_p-1:0];
`ifdef SOBEL_MAG_THRESHOLD_EN
    pix    = (32'(mag) >= threshold_p) ? '1 : '0;
`else
    pix    = mag;
`endif
    v2_d   = adv2 ? v1_q : v2_q;
    data_d = data_q;
    if (ld2) begin
      data_d = border_q ? '0 : pix;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      gx_q     <= '0;
      gy_q     <= '0;
      border_q <= 1'b0;
      data_q   <= '0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      col_q    <= col_d;
      row_q    <= row_d;
      gx_q     <= gx_d;
      gy_q     <= gy_d;
      border_q <= border_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    valid_o = v2_q;
    data_o  = data_q;
  end

endmodule

// File: tb/tb_sobel_mag.sv
// Directed bench for sobel_mag on an 8x4 frame of 8-bit pixels.
module tb_sobel_mag;

  localparam int unsigned W = 8;

  logic                   clk = 1'b0;
  logic                   reset_i;
  logic                   valid_i;
  logic                   ready_o;
  logic [2:0][2:0][W-1:0] kernel;
  logic                   valid_o;
  logic                   ready_i;
  logic [W-1:0]           data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sobel_mag #(
    .linewidth_px_p(8),
    .frame_height_p(4),
    .width_p       (8)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .kernel_i(kernel),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0][2:0][W-1:0] cols(input logic [W-1:0] c0,
                                                   input logic [W-1:0] c1,
                                                   input logic [W-1:0] c2);
    logic [2:0][2:0][W-1:0] k;
    for (int r = 0; r < 3; r++) begin
      k[r][0] = c0;
      k[r][1] = c1;
      k[r][2] = c2;
    end
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated window: accept, expect it 2 edges later, then drained.
  task automatic send_one(input logic [2:0][2:0][W-1:0] k, input logic [W-1:0] exp, input string tag);
    kernel  = k;
    valid_i = 1'b1;
    #1;
    check({tag, "_rdy"}, ready_o, 1);
    tick();
    valid_i = 1'b0;
    tick();
    check({tag, "_vld"}, valid_o, 1);
    check(tag, data_o, exp);
    tick();
    check({tag, "_drain"}, valid_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0][2:0][W-1:0] v_edge;
    logic [2:0][2:0][W-1:0] sat_win;
    logic [W-1:0]           bp_exp [10];
    int                     nout;
    int                     idx;
    int                     infl;
    int                     cyc;
    bit                     in_x;
    bit                     out_x;
    bit                     stall;
    logic [W-1:0]           held;

    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    kernel  = '0;
    v_edge  = cols(8'd0, 8'd0, 8'd50);
    // Gx = 1020, Gy = 510 -> 1530, saturates.
    sat_win = cols(8'd0, 8'd0, 8'd255);
    sat_win[2][1] = 8'd255;
    bp_exp = '{8'd20, 8'd40, 8'd60, 8'd80, 8'd100, 8'd120, 8'd0, 8'd0, 8'd180, 8'd200};

    repeat (2) tick();
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    reset_i = 1'b0;
    #1;
    check("rst_ready", ready_o, 1);
    tick();
    check("idle_valid", valid_o, 0);

    // Flat frame: 32 windows, all zero gradient.
    kernel  = cols(8'd100, 8'd100, 8'd100);
    valid_i = 1'b1;
    nout    = 0;
    for (int i = 0; i < 34; i++) begin
      tick();
      if (i == 0) check("lat_edge1", valid_o, 0);
      if (i == 1) check("lat_edge2", valid_o, 1);
      if (valid_o) begin
        check("flat_data", data_o, 0);
        nout++;
      end
      if (i == 31) valid_i = 1'b0;
    end
    check("flat_count", nout, 32);

    // Frame walk: rows 0/1 are border, then row 2 and 3 interiors.
    for (int i = 0; i < 16; i++) send_one(v_edge, 8'd0, "border_r01");
    send_one(v_edge, 8'd0, "border_r2c0");
    send_one(v_edge, 8'd0, "border_r2c1");
    send_one(v_edge, 8'd200, "vedge_r2c2");
    send_one(sat_win, 8'd255, "sat_r2c3");
    send_one(cols(8'd50, 8'd0, 8'd0), 8'd200, "neg_gx_r2c4");
    send_one(cols(8'd0, 8'd0, 8'd63), 8'd252, "mag252_r2c5");
    send_one(cols(8'd0, 8'd0, 8'd64), 8'd255, "mag256_r2c6");
    send_one(v_edge, 8'd200, "vedge_r2c7");
    send_one(v_edge, 8'd0, "colwrap_r3c0");
    send_one(v_edge, 8'd0, "border_r3c1");
    for (int i = 0; i < 6; i++) send_one(v_edge, 8'd200, "vedge_r3");
    for (int i = 0; i < 3; i++) send_one(v_edge, 8'd0, "rowwrap_r0");

    // Mid-frame reset with two windows in flight.
    kernel  = v_edge;
    valid_i = 1'b1;
    repeat (13) tick();
    valid_i = 1'b0;
    reset_i = 1'b1;
    tick();
    check("midrst_valid", valid_o, 0);
    check("midrst_data", data_o, 0);
    reset_i = 1'b0;
    #1;
    check("midrst_ready", ready_o, 1);
    tick();
    check("midrst_flushed", valid_o, 0);
    send_one(v_edge, 8'd0, "postrst_c0");
    send_one(v_edge, 8'd0, "postrst_c1");
    send_one(v_edge, 8'd0, "postrst_r0c2");

    // Advance from row0 col3 to row2 col2 with filler windows.
    kernel  = cols(8'd7, 8'd7, 8'd7);
    valid_i = 1'b1;
    repeat (15) tick();
    valid_i = 1'b0;
    repeat (3) tick();

    // Backpressure: ready_i pattern 1,0,0 repeating.
    idx   = 0;
    nout  = 0;
    infl  = 0;
    cyc   = 0;
    stall = 1'b0;
    held  = '0;
    while (nout < 10 && cyc < 200) begin
      ready_i = (cyc % 3 == 0);
      valid_i = (idx < 10);
      if (idx < 10) kernel = cols(8'd0, 8'd0, 8'(5 * (idx + 1)));
      #1;
      if (stall) begin
        check("hold_valid", valid_o, 1);
        check("hold_data", data_o, held);
      end
      check("bp_ready", ready_o, !(infl == 2 && !ready_i));
      in_x  = valid_i & ready_o;
      out_x = valid_o & ready_i;
      if (out_x) begin
        check("bp_data", data_o, bp_exp[nout]);
        nout++;
      end
      stall = valid_o & !ready_i;
      held  = data_o;
      @(posedge clk);
      #1;
      idx  += int'(in_x);
      infl += int'(in_x) - int'(out_x);
      cyc++;
    end
    check("bp_count", nout, 10);
    check("bp_accepted", idx, 10);
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (2) tick();
    check("bp_drained", valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
